// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROR/RRX with C flag, tag sideband,
// valid/ready flow control, flush and in-flight tag lookup.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready   : request handshake
//   sh, rrx, carry_in   : operation select and current C flag
//   data, amount, tag_in: operand, shift count, sideband tag
//   flush               : kill all in-flight requests
//   out_valid/out_ready : result handshake
//   result, carry_out, tag_out : registered result
//   query_tag/query_hit : combinational in-flight tag lookup
module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sh,
  input  logic             rrx,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       amount,
  input  logic [TAGW-1:0]  tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [TAGW-1:0]  tag_out,
  input  logic [TAGW-1:0]  query_tag,
  output logic             query_hit
);

  localparam int LG = $clog2(WIDTH);
  localparam int NM = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [7:0] WN = 8'(WIDTH);

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] v;
    logic [7:0]       n;
    logic [1:0]       sh;
    logic             sgn;
    logic             cin;
    logic [TAGW-1:0]  tag;
  } pay_t;

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] y;
    for (int i = 0; i < WIDTH; i++) y[i] = x[WIDTH-1-i];
    return y;
  endfunction

  // Every mode is a right rotate by n mod WIDTH; LSL is done on the
  // bit-reversed operand. Only layers lo..hi-1 are applied here.
  function automatic pay_t layers(
    input pay_t p,
    input int   lo,
    input int   hi
  );
    pay_t q;
    q = p;
    for (int i = 0; i < LG; i++) begin
      if (i >= lo && i < hi && q.n[i]) begin
        q.v = (q.v >> (1 << i)) | (q.v << (WIDTH - (1 << i)));
      end
    end
    return q;
  endfunction

  logic             en;
  logic [STAGES-1:0] vld_q;
  pay_t             head;
  pay_t             fin;
  pay_t             stg_d [NM];
  pay_t             stg_q [NM];
  logic [WIDTH-1:0] res_d, res_q;
  logic             co_d, co_q;
  logic [TAGW-1:0]  tag_q;

  assign out_valid = vld_q[STAGES-1];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = reset & en & ~flush;
  assign result    = res_q;
  assign carry_out = co_q;
  assign tag_out   = tag_q;

  // RRX is folded into an amount-0 request with pre-rotated data.
  always_comb begin
    head.v   = (sh == LSL) ? rev(data) : data;
    head.n   = amount;
    head.sh  = sh;
    head.sgn = data[WIDTH-1];
    head.cin = carry_in;
    head.tag = tag_in;
    if (rrx) begin
      head.v   = {carry_in, data[WIDTH-1:1]};
      head.n   = '0;
      head.sh  = ROR;
      head.cin = data[0];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = (s * LG) / STAGES;
    localparam int HI = ((s + 1) * LG) / STAGES;
    pay_t src;
    if (s == 0) begin : g_first
      assign src = head;
    end else begin : g_mid
      assign src = stg_q[s-1];
    end
    if (s == STAGES - 1) begin : g_last
      assign fin = layers(src, LO, HI);
    end else begin : g_reg
      assign stg_d[s] = layers(src, LO, HI);
    end
  end

  // After the rotate, the bit shifted out last sits at the MSB.
  always_comb begin
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] fill;
    mask  = {WIDTH{1'b1}} >> fin.n[LG-1:0];
    fill  = {WIDTH{fin.sgn}};
    res_d = fin.v & mask;
    co_d  = fin.v[WIDTH-1];
    if (fin.n == '0) begin
      res_d = fin.v;
      co_d  = fin.cin;
    end else if (fin.sh == ROR) begin
      res_d = fin.v;
    end else if (fin.sh == ASR) begin
      if (fin.n >= WN) begin
        res_d = fill;
        co_d  = fin.sgn;
      end else begin
        res_d = (fin.v & mask) | (fill & ~mask);
      end
    end else if (fin.n >= WN) begin
      res_d = '0;
      if (fin.n != WN) co_d = 1'b0;
    end
    if (fin.sh == LSL) res_d = rev(res_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      res_q <= '0;
      co_q  <= 1'b0;
      tag_q <= '0;
      for (int s = 0; s < NM; s++) stg_q[s] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
      for (int s = 0; s < STAGES - 1; s++) stg_q[s] <= stg_d[s];
      res_q <= res_d;
      co_q  <= co_d;
      tag_q <= fin.tag;
    end
  end

  always_comb begin
    query_hit = vld_q[STAGES-1] && (tag_q == query_tag);
    for (int s = 0; s < STAGES - 1; s++) begin
      if (vld_q[s] && stg_q[s].tag == query_tag) query_hit = 1'b1;
    end
  end

endmodule
